sumador_64_bits_serie: RTL and testbench
========================================

# sumador_64_bits_serie

Nibble-serial 64-bit adder: captures two operands plus carry-in through a valid/ready handshake, then adds one 4-bit chunk per clock, LSB chunk first, through a single `sumador_4_bits` instance with a registered carry between chunks. It is the area-minimal alternative to the fully combinational 64-bit chain. It sits directly above `sumador_4_bits`, feeding it operand slices and collecting its sum/cout every cycle. Results are presented through a valid/ready output handshake.

## Interface
Parameters:
- `WIDTH`, 64: operand width. Must be a multiple of 4 and at least 8.

Ports:
- `clk`  in  1: rising-edge clock, single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry-in.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `sum`  out  WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout`  out  1: carry out of the MSB.
- `overflow`  out  1: signed overflow. Present only with `SUMADOR_OVERFLOW_EN`.

## Operation
- FSM has three states: IDLE, RUN, DONE. Encoding is an enum from the package.
- Accept occurs when `in_valid && in_ready`. On accept, latch `a`, `b` and `cin` into shift/carry registers, clear the chunk counter, and go to RUN.
- `in_ready` = (IDLE) || (DONE && `out_ready`). Back-to-back accept is allowed on the same edge the result is consumed.
- RUN: each cycle feeds bits [3:0] of the A/B shift registers and the carry register to `sumador_4_bits`.
  - The 4-bit sum shifts into the result register from the top.
  - cout is stored as the next carry.
  - A/B shift right by 4.
  - The counter increments, width $clog2(WIDTH/4).
- After chunk WIDTH/4-1, go to DONE. `sum` holds the full result and `cout` holds the final carry.
- DONE: `out_valid`=1; `sum`, `cout` and `overflow` are held stable.
  - If `out_ready`: go to IDLE, or to RUN if a new accept happens on the same edge.
- Inputs `a`, `b`, `cin` are ignored outside an accepting edge. Changes during RUN have no effect.
- `out_ready` is ignored unless in DONE.
- Counter wrap: the terminal count is detected explicitly. The counter never wraps into a second pass.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0. Counter, shift registers and carry register are also 0.
- `rst` has priority over every other event.
  - Reset mid-RUN or in DONE discards the operation; no `out_valid` is ever produced for it.
  - The cycle after reset, the block is in IDLE.
- Latency: accept on edge k; `out_valid` rises after edge k+WIDTH/4 (edge k+16 for the default).
- Throughput: one result per WIDTH/4+1 cycles when `out_ready` is held high, thanks to back-to-back accept.
- All outputs are registered. There is no combinational path from inputs to outputs, except `in_ready` depending on `out_ready` in DONE.
- Arithmetic: no width growth. The carry register is 1 bit; `cout` is the carry out of the final chunk.

## Configuration
- `SUMADOR_OVERFLOW_EN` defined:
  - Adds a 1-bit carry-into-MSB register, captured at the last chunk from bit 3 internal carry logic (a[W-1]^b[W-1]^sum[W-1]).
  - Adds the `overflow` port = carry-into-MSB XOR `cout`, registered, valid with `out_valid`, reset 0.
- Undefined: no `overflow` port and no extra logic. All other behaviour is identical.

## Structure
- Package `sumador_pkg` holds:
  - `CHUNK_W` = 4.
  - The state enum type `sumador_estado_t` (IDLE, RUN, DONE).
  - A function returning the chunk count for a given WIDTH.
- One sub-module: `sumador_4_bits`, instantiated once as the datapath. The FSM, counter and shift registers live in this block.

## Test plan
- Zero operands: a=0, b=0, cin=0 → after 16 edges `out_valid`=1, `sum`=0, `cout`=0; `in_ready`=0 throughout RUN.
- Full ripple: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0 → `sum`=0, `cout`=1.
- Carry-in: a=0123_4567_89AB_CDEF, b=FEDC_BA98_7654_3210, cin=1 → `sum`=0, `cout`=1. Repeat with cin=0 → `sum`=FFFF_FFFF_FFFF_FFFF, `cout`=0.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 5 cycles in DONE → `sum` stable, `in_ready`=0.
  - Then raise `out_ready` together with `in_valid` (a=1, b=2) → next result `sum`=3, 16 edges later.
- Reset mid-operation: assert `rst` for 1 cycle at chunk 7 → next cycle IDLE, `sum`=0, `out_valid`=0, `in_ready`=1; no result appears.
- With `SUMADOR_OVERFLOW_EN`:
  - a=7FFF_FFFF_FFFF_FFFF, b=1 → `overflow`=1, `cout`=0.
  - a=b=8000_0000_0000_0000 → `sum`=0, `cout`=1, `overflow`=1.
  - a=FFFF_FFFF_FFFF_FFFF, b=1 → `overflow`=0.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared definitions for the nibble-serial adder: chunk width, FSM states
// and the chunk-count helper.
package sumador_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sumador_estado_t;

  function automatic int chunk_count(input int width);
    return width / CHUNK_W;
  endfunction

endpackage

// File: rtl/sumador_4_bits.sv
// Combinational 4-bit ripple-carry adder, the datapath slice of the
// nibble-serial adder.
module sumador_4_bits
  import sumador_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  logic [CHUNK_W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < CHUNK_W; gi++) begin : g_bit
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[CHUNK_W];

endmodule

// File: rtl/sumador_64_bits_serie.sv
// Nibble-serial WIDTH-bit adder with valid/ready handshakes on both sides.
// Define SUMADOR_OVERFLOW_EN to add the registered signed-overflow output.
module sumador_64_bits_serie
  import sumador_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SUMADOR_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             cout
);

  localparam int N_CHUNKS = chunk_count(WIDTH);
  localparam int CNT_W    = $clog2(N_CHUNKS);

  sumador_estado_t state_reg, state_next;

  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
  logic               carry_reg, cout_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_cout;
  logic               accept, last_chunk;

  sumador_4_bits u_sumador_4_bits (
    .a    (a_reg[CHUNK_W-1:0]),
    .b    (b_reg[CHUNK_W-1:0]),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // in_ready is the only combinational output: a result can be consumed and
  // a new operand pair accepted on the same edge.
  assign in_ready   = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (cnt_reg == CNT_W'(N_CHUNKS - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
        // Chunk results enter from the top so the LSB chunk ends up at bit 0.
        sum_reg   <= {chunk_sum, sum_reg[WIDTH-1:CHUNK_W]};
        a_reg     <= a_reg >> CHUNK_W;
        b_reg     <= b_reg >> CHUNK_W;
        carry_reg <= chunk_cout;
        if (last_chunk) begin
          cout_reg <= chunk_cout;
        end else begin
          cnt_reg  <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

`ifdef SUMADOR_OVERFLOW_EN
  logic overflow_reg;

  // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (!accept && (state_reg == RUN) && last_chunk) begin
      overflow_reg <= (a_reg[CHUNK_W-1] ^ b_reg[CHUNK_W-1] ^ chunk_sum[CHUNK_W-1])
                      ^ chunk_cout;
    end
  end

  assign overflow = overflow_reg;
`endif

  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_sumador_64_bits_serie.sv
// Directed self-checking bench for sumador_64_bits_serie; overflow checks
// are included when SUMADOR_OVERFLOW_EN is defined.
module tb_sumador_64_bits_serie;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SUMADOR_OVERFLOW_EN
  logic             overflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] held_sum;

  always #5 clk = ~clk;

  sumador_64_bits_serie #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SUMADOR_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .cout      (cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    step();
    in_valid = 1'b0;
  endtask

  // Edges k+1..k+15: still running; operand inputs scrambled to prove they are ignored.
  task automatic wait_run(input string tag);
    for (int i = 0; i < WIDTH / 4 - 1; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom);
      step();
      chk({tag, "_run_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_run_in_ready"}, 64'(in_ready), 64'd0);
    end
    step();
  endtask

  task automatic expect_result(input string tag, input logic [WIDTH-1:0] es, input logic ec);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    $display("op %s: sum=%h cout=%0b out_valid=%0b", tag, sum, cout, out_valid);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, input logic [WIDTH-1:0] es, input logic ec);
    start(va, vb, vc);
    wait_run(tag);
    expect_result(tag, es, ec);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", sum, 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
`ifdef SUMADOR_OVERFLOW_EN
    chk("reset_overflow", 64'(overflow), 64'd0);
`endif

    run_op("zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    consume("zero");

    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
    consume("ripple");

    run_op("cin1", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'd0, 1'b1);
    consume("cin1");

    // Backpressure: result held while out_ready is low.
    run_op("cin0", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    held_sum = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      a = {$urandom, $urandom};
      in_valid = 1'b1;
      step();
      chk("hold_sum", sum, held_sum);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;

    // Back-to-back accept on the consuming edge.
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 64'd1;
    b = 64'd2;
    cin = 1'b0;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_accepted_out_valid", 64'(out_valid), 64'd0);
    wait_run("b2b");
    expect_result("b2b", 64'd3, 1'b0);
    consume("b2b");

    // Reset at chunk 7 discards the operation.
    start(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_sum", sum, 64'd0);
    chk("rst_mid_cout", 64'(cout), 64'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst_mid_no_result", 64'(out_valid), 64'd0);
    end
    $display("op rst_mid: discarded, out_valid=%0b in_ready=%0b", out_valid, in_ready);

`ifdef SUMADOR_OVERFLOW_EN
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    chk("ovf_pos_overflow", 64'(overflow), 64'd1);
    consume("ovf_pos");
    run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1);
    chk("ovf_neg_overflow", 64'(overflow), 64'd1);
    consume("ovf_neg");
    run_op("ovf_none", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
    chk("ovf_none_overflow", 64'(overflow), 64'd0);
    consume("ovf_none");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
